// File: rtl/sram_responder_if.sv
// sram_responder_if: controller-to-responder SRAM control/address bus plus status.
// master: SRAM controller side (drives address and strobes, observes status).
// slave : sram_responder side (observes address and strobes, reports status).
// The 16-bit data bus is a plain inout port on the responder, not part of this bundle.
interface sram_responder_if;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic        ContentionErr;
  logic [15:0] ReadCount;
  logic [15:0] WriteCount;
  modport master (output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
                  input ContentionErr, ReadCount, WriteCount);
  modport slave (input SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
                 output ContentionErr, ReadCount, WriteCount);
endinterface

// File: rtl/sram_responder.sv
// sram_responder: behavioural asynchronous-SRAM model with configurable read latency.
// Ports: SRAM_CLK (clock), RESET (async, active high), SRAM_DQ (16-bit tristate data),
//        bus (sram_responder_if.slave: address, CE/OE/WE/UB/LB strobes, ContentionErr,
//        ReadCount, WriteCount).
// Macro SRAM_RESPONDER_STATS_EN enables the read/write counters; otherwise they read 0.
module sram_responder #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 2
) (
  input  logic              SRAM_CLK,
  input  logic              RESET,
  inout  wire  [15:0]       SRAM_DQ,
  sram_responder_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE} state_t;
  localparam logic [3:0] LOAD = 4'(READ_LAT - 1);
  state_t state;
  logic [ADDR_W-1:0] r_addr, raddr, waddr;
  logic [15:0] r_dq, rdata, wdata;
  logic r_ce, r_oe, r_we, r_ub, r_lb, wub, wlb, cerr;
  logic [3:0] cnt;
  logic [15:0] mem [2**ADDR_W];
  logic wr_req, rd_req, rd_go, commit, drive;
  logic unused_addr;
  assign unused_addr = ^bus.SRAM_ADDR;
  assign wr_req = !r_ce && !r_we;
  assign rd_req = !r_ce && !r_oe && r_we;
  assign rd_go  = state == READ_WAIT && rd_req && cnt == '0;
  assign commit = state == WRITE && !wr_req;
  assign drive  = state == READ_DRIVE;
  // Lane enables follow the registered byte strobes while the drive state holds.
  assign SRAM_DQ = {drive && !r_ub ? rdata[15:8] : 8'hzz, drive && !r_lb ? rdata[7:0] : 8'hzz};
  assign bus.ContentionErr = cerr;
  always_ff @(posedge SRAM_CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      {r_ce, r_oe, r_we, r_ub, r_lb} <= '1;
      r_addr <= '0;
      r_dq <= '0;
      raddr <= '0;
      waddr <= '0;
      rdata <= '0;
      wdata <= '0;
      wub <= 1'b1;
      wlb <= 1'b1;
      cnt <= '0;
      cerr <= 1'b0;
    end else begin
      r_ce <= bus.SRAM_CE_N;
      r_oe <= bus.SRAM_OE_N;
      r_we <= bus.SRAM_WE_N;
      r_ub <= bus.SRAM_UB_N;
      r_lb <= bus.SRAM_LB_N;
      r_addr <= bus.SRAM_ADDR[ADDR_W-1:0];
      r_dq <= SRAM_DQ;
      case (state)
        IDLE:
          if (wr_req) state <= WRITE;
          else if (rd_req) begin
            state <= READ_WAIT;
            raddr <= r_addr;
            cnt <= LOAD;
          end
        READ_WAIT, READ_DRIVE:
          if (wr_req) begin
            state <= WRITE;
            cerr <= 1'b1;
          end else if (!rd_req) state <= IDLE;
          else if (state == READ_DRIVE) begin
            if (r_addr != raddr) begin
              state <= READ_WAIT;
              raddr <= r_addr;
              cnt <= LOAD;
            end
          end else if (rd_go) begin
            state <= READ_DRIVE;
            rdata <= mem[raddr];
          end else cnt <= cnt - 1'b1;
        default:
          if (!wr_req) state <= IDLE;
      endcase
      // Every cycle a write is requested the latest bus contents are captured; the
      // commit edge has wr_req low, so the last captured write is what lands in memory.
      if (wr_req) begin
        waddr <= r_addr;
        wdata <= r_dq;
        wub <= r_ub;
        wlb <= r_lb;
      end
    end
  // Memory is deliberately not reset; commit is low while RESET holds state at IDLE.
  always_ff @(posedge SRAM_CLK)
    if (commit) begin
      if (!wub) mem[waddr][15:8] <= wdata[15:8];
      if (!wlb) mem[waddr][7:0] <= wdata[7:0];
    end
`ifdef SRAM_RESPONDER_STATS_EN
  logic [15:0] rc, wc;
  always_ff @(posedge SRAM_CLK or posedge RESET)
    if (RESET) begin
      rc <= '0;
      wc <= '0;
    end else begin
      if (rd_go) rc <= rc + 1'b1;
      if (commit) wc <= wc + 1'b1;
    end
  assign bus.ReadCount  = rc;
  assign bus.WriteCount = wc;
`else
  assign bus.ReadCount  = 16'h0000;
  assign bus.WriteCount = 16'h0000;
`endif
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed self-checking bench for sram_responder (ADDR_W=10, READ_LAT=2).
// DQ carries pullups, so any lane the responder leaves high-Z reads back as 8'hFF.
module tb_sram_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_oe = 1'b0;
  logic [15:0] tb_dq = 16'h0000;
  wire [15:0] dq;
  int n_chk = 0;
  int n_fail = 0;
`ifdef SRAM_RESPONDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  sram_responder_if bus();
  assign dq = tb_oe ? tb_dq : 16'hzzzz;
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (dq[g]);
  end
  sram_responder #(.ADDR_W(10), .READ_LAT(2)) dut (
    .SRAM_CLK(clk),
    .RESET(rst),
    .SRAM_DQ(dq),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] cnt(input int n);
    return STATS ? 16'(n) : 16'h0000;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.SRAM_CE_N = 1'b1;
    bus.SRAM_OE_N = 1'b1;
    bus.SRAM_WE_N = 1'b1;
    tb_oe = 1'b0;
    tick(3);
  endtask
  task automatic wr(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb, input int n);
    bus.SRAM_ADDR = a;
    bus.SRAM_UB_N = ub;
    bus.SRAM_LB_N = lb;
    tb_dq = d;
    tb_oe = 1'b1;
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_WE_N = 1'b0;
    tick(n);
    idle();
  endtask
  task automatic rd(input logic [19:0] a, input logic ub, input logic lb);
    bus.SRAM_ADDR = a;
    bus.SRAM_UB_N = ub;
    bus.SRAM_LB_N = lb;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_OE_N = 1'b0;
  endtask
  initial begin
    bus.SRAM_ADDR = '0;
    bus.SRAM_CE_N = 1'b1;
    bus.SRAM_OE_N = 1'b1;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_UB_N = 1'b1;
    bus.SRAM_LB_N = 1'b1;
    tick(2);
    chk("reset_dq", dq, 16'hFFFF);
    chk("reset_cerr", 16'(bus.ContentionErr), 16'h0000);
    chk("reset_rc", bus.ReadCount, 16'h0000);
    chk("reset_wc", bus.WriteCount, 16'h0000);
    rst = 1'b0;
    tick(1);
    // Write to the top of the 20-bit space, read back through its 10-bit alias.
    wr(20'hFFFFF, 16'hF0F0, 1'b0, 1'b0, 2);
    rd(20'h003FF, 1'b0, 1'b0);
    tick(3);
    chk("alias_lat_early", dq, 16'hFFFF);
    tick(1);
    chk("alias_lat_exact", dq, 16'hF0F0);
    chk("alias_rc", bus.ReadCount, cnt(1));
    chk("alias_wc", bus.WriteCount, cnt(1));
    chk("alias_cerr", 16'(bus.ContentionErr), 16'h0000);
    idle();
    chk("release_dq", dq, 16'hFFFF);
    // Byte-lane merge, then lane masking on read.
    wr(20'h00010, 16'hABCD, 1'b0, 1'b0, 1);
    wr(20'h00010, 16'h1200, 1'b0, 1'b1, 1);
    rd(20'h00010, 1'b0, 1'b0);
    tick(4);
    chk("lane_merge", dq, 16'h12CD);
    bus.SRAM_UB_N = 1'b1;
    tick(1);
    chk("ub_off_z", dq, 16'hFFCD);
    bus.SRAM_UB_N = 1'b0;
    tick(1);
    chk("ub_back_on", dq, 16'h12CD);
    chk("merge_wc", bus.WriteCount, cnt(3));
    // Write request while driving: released on the FSM edge, sticky error, commit.
    tb_dq = 16'h5555;
    tb_oe = 1'b1;
    bus.SRAM_WE_N = 1'b0;
    tick(2);
    chk("contention_release", dq, 16'h5555);
    chk("contention_flag", 16'(bus.ContentionErr), 16'h0001);
    tick(2);
    idle();
    chk("contention_sticky", 16'(bus.ContentionErr), 16'h0001);
    chk("contention_wc", bus.WriteCount, cnt(4));
    rd(20'h00010, 1'b0, 1'b0);
    tick(4);
    chk("contention_data", dq, 16'h5555);
    chk("contention_rc", bus.ReadCount, cnt(3));
    idle();
    // Address step while driving re-enters the latency wait.
    wr(20'h00001, 16'h1111, 1'b0, 1'b0, 1);
    wr(20'h00002, 16'h2222, 1'b0, 1'b0, 1);
    rd(20'h00001, 1'b0, 1'b0);
    tick(4);
    chk("step_first", dq, 16'h1111);
    bus.SRAM_ADDR = 20'h00002;
    tick(1);
    chk("step_hold", dq, 16'h1111);
    tick(1);
    chk("step_gap", dq, 16'hFFFF);
    tick(1);
    chk("step_early", dq, 16'hFFFF);
    tick(1);
    chk("step_second", dq, 16'h2222);
    chk("step_rc", bus.ReadCount, cnt(5));
    idle();
    // Reset in the middle of a write discards it; memory survives reset.
    wr(20'h00020, 16'h0000, 1'b0, 1'b0, 1);
    chk("pre_reset_wc", bus.WriteCount, cnt(7));
    bus.SRAM_ADDR = 20'h00020;
    tb_dq = 16'h7777;
    tb_oe = 1'b1;
    bus.SRAM_CE_N = 1'b0;
    bus.SRAM_WE_N = 1'b0;
    tick(3);
    tb_oe = 1'b0;
    bus.SRAM_CE_N = 1'b1;
    bus.SRAM_WE_N = 1'b1;
    rst = 1'b1;
    #2;
    chk("midwr_rst_dq", dq, 16'hFFFF);
    chk("midwr_rst_cerr", 16'(bus.ContentionErr), 16'h0000);
    chk("midwr_rst_rc", bus.ReadCount, 16'h0000);
    chk("midwr_rst_wc", bus.WriteCount, 16'h0000);
    tick(1);
    rst = 1'b0;
    tick(2);
    // A commit with both lanes disabled counts but leaves the word alone.
    wr(20'h00020, 16'hBEEF, 1'b1, 1'b1, 1);
    chk("nolane_wc", bus.WriteCount, cnt(1));
    rd(20'h00020, 1'b0, 1'b0);
    tick(4);
    chk("discarded_write", dq, 16'h0000);
    idle();
    rd(20'h003FF, 1'b0, 1'b0);
    tick(4);
    chk("mem_kept", dq, 16'hF0F0);
    chk("final_rc", bus.ReadCount, cnt(2));
    idle();
    // Write immediately followed by a read of the same word.
    wr(20'h00030, 16'hC3A5, 1'b0, 1'b0, 1);
    rd(20'h00030, 1'b0, 1'b0);
    tick(4);
    chk("wr_then_rd", dq, 16'hC3A5);
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning number of low SRAM_ADDR bits decoded (depth 2^ADDR_W 16-bit words).
REQ-002 SHALL have parameter READ_LAT, default 2, meaning clock cycles from read-request sample to DQ drive (legal range 1..15).
REQ-003 SHALL have port SRAM_CLK  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port SRAM_DQ  inout  16  data bus; driven only during the read-drive state, else high-Z.
REQ-006 SHALL have port SRAM_ADDR  input  20  word address from the SRAM controller.
REQ-007 SHALL have ports SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  input  1 each  active-low chip enable, output enable, write enable.
REQ-008 SHALL have ports SRAM_UB_N, SRAM_LB_N  input  1 each  active-low byte lanes: UB = DQ[15:8], LB = DQ[7:0].
REQ-009 SHALL have port ContentionErr  output  1  sticky flag: write request arrived while DQ was being driven.
REQ-010 SHALL have ports ReadCount, WriteCount  output  16 each  completed read / committed write counters.

Function
REQ-011 SHALL register all SRAM_* inputs once per cycle; the FSM SHALL act only on registered values.
REQ-012 SHALL implement FSM states IDLE, READ_WAIT, READ_DRIVE, WRITE.
REQ-013 IDLE -> WRITE SHALL occur when CE_N=0 and WE_N=0, regardless of OE_N (write priority).
REQ-014 IDLE -> READ_WAIT SHALL occur when CE_N=0, OE_N=0, WE_N=1; address captured, latency counter loaded with READ_LAT-1.
REQ-015 READ_WAIT SHALL decrement each cycle and enter READ_DRIVE when the counter is 0; the first DQ drive SHALL be exactly READ_LAT cycles after the registered request.
REQ-016 In READ_DRIVE, DQ SHALL carry mem[addr]; each lane SHALL be driven only if its _N is 0, else that lane is high-Z.
REQ-017 In READ_DRIVE, an address change with CE_N=0, OE_N=0, WE_N=1 SHALL return to READ_WAIT with the new address and a reloaded counter.
REQ-018 READ_WAIT or READ_DRIVE SHALL return to IDLE, releasing DQ the next cycle, when CE_N=1 or OE_N=1.
REQ-019 ReadCount SHALL increment by 1 on each entry to READ_DRIVE and wrap FFFF -> 0000.
REQ-020 In WRITE, the module SHALL sample DQ, address and UB_N/LB_N every cycle WE_N=0 and CE_N=0.
REQ-021 Leaving WRITE (WE_N=1 or CE_N=1) SHALL commit the last sampled data to enabled lanes only at the last sampled address, then go to IDLE.
REQ-022 WriteCount SHALL increment by 1 per commit and wrap FFFF -> 0000; a commit with both lanes disabled SHALL still count but leave memory unchanged.
REQ-023 Addresses SHALL use SRAM_ADDR[ADDR_W-1:0] only; upper bits ignored (aliasing).
REQ-024 WE_N=0 and CE_N=0 sampled in READ_WAIT or READ_DRIVE SHALL set ContentionErr and go to WRITE; DQ SHALL be released that same clock edge.
REQ-025 A read in the cycle after a commit to the same address SHALL return the newly committed data.

Reset
REQ-026 RESET SHALL force IDLE, DQ high-Z, ContentionErr=0, ReadCount=0, WriteCount=0, latency counter=0, input registers to inactive (all _N=1).
REQ-027 RESET during WRITE SHALL discard the uncommitted write; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro SRAM_RESPONDER_STATS_EN defined: ReadCount and WriteCount SHALL operate per REQ-019/REQ-022.
REQ-029 Macro SRAM_RESPONDER_STATS_EN undefined: counters SHALL be omitted and ReadCount, WriteCount SHALL be tied to 16'h0000; all other behaviour unchanged.

Verification
REQ-030 Write 16'hF0F0 to 20'hFFFFF, UB/LB both 0, WE_N pulse 2 cycles; then read 20'h003FF -> DQ=16'hF0F0 exactly 2 cycles after request (READ_LAT=2), ReadCount=1, WriteCount=1.
REQ-031 Write 16'hABCD to 20'h00010, then write 16'h1200 with UB_N=0, LB_N=1; read -> 16'h12CD; read with UB_N=1 -> DQ[15:8]=Z, DQ[7:0]=CD.
REQ-032 In READ_DRIVE at 20'h00010, assert WE_N=0 with DQ=16'h5555 -> DQ released same edge, ContentionErr=1 and stays 1, commit yields mem=16'h5555.
REQ-033 Assert RESET mid-WRITE (data 16'h7777 to 20'h00020, prior 16'h0000) -> DQ Z, counters 0, later read of 20'h00020 returns 16'h0000.
REQ-034 Hold CE_N=0, OE_N=0, step address 20'h00001 -> 20'h00002 during READ_DRIVE -> DQ re-driven with new word after 2 cycles, ReadCount=2.
REQ-035 Run REQ-030 without SRAM_RESPONDER_STATS_EN -> identical DQ timing, ReadCount=WriteCount=16'h0000.
